// File: rtl/burst_addr_gen_pkg.sv
// Shared types for the AHB burst address generator: transfer/burst encodings,
// FSM states and the burst-type decode helper.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package burst_addr_gen_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } trans_types_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } burst_types_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIXED = 2'd1,
        ST_UNDEF = 2'd2
    } state_e;

    // beats == 0 marks an undefined-length (INCR) burst
    typedef struct packed {
        logic [4:0] beats;
        logic       wrap;
    } burst_info_t;

    // Bit index of the 1 KB boundary an incrementing burst must not cross
    localparam int KB_BIT = 10;

    function automatic burst_info_t burst_info(input logic [2:0] hburst);
        burst_info_t info;
        info.beats = 5'd1;
        info.wrap  = 1'b0;
        case (hburst)
            BURST_SINGLE: info.beats = 5'd1;
            BURST_INCR:   info.beats = 5'd0;
            BURST_WRAP4:  begin info.beats = 5'd4;  info.wrap = 1'b1; end
            BURST_INCR4:  info.beats = 5'd4;
            BURST_WRAP8:  begin info.beats = 5'd8;  info.wrap = 1'b1; end
            BURST_INCR8:  info.beats = 5'd8;
            BURST_WRAP16: begin info.beats = 5'd16; info.wrap = 1'b1; end
            BURST_INCR16: info.beats = 5'd16;
            default:      info.beats = 5'd1;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/burst_addr_gen_next_addr.sv
// burst_next_addr: address of the beat following i_addr for the given size and burst shape.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: i_addr current address, i_hsize log2 bytes, i_beats burst length (0 = undefined),
//        i_wrap wrapping burst, o_next_addr following beat address.
module burst_next_addr
    import burst_addr_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_hsize,
    input  logic [4:0]        i_beats,
    input  logic              i_wrap,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_mask;
    logic [2:0]        w_span_shift;

    // Burst lengths are powers of two, so the wrap span is step << log2(beats)
    always_comb begin
        w_span_shift = 3'd0;
        case (i_beats)
            5'd4:    w_span_shift = 3'd2;
            5'd8:    w_span_shift = 3'd3;
            5'd16:   w_span_shift = 3'd4;
            default: w_span_shift = 3'd0;
        endcase
    end

    assign w_step      = ADDR_W'(1) << i_hsize;
    assign w_incr      = i_addr + w_step;
    assign w_mask      = (w_step << w_span_shift) - ADDR_W'(1);
    assign o_next_addr = i_wrap ? ((i_addr & ~w_mask) | (w_incr & w_mask)) : w_incr;

endmodule

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: tracks AHB bursts and presents the data-phase beat address, index and errors.
// Latency: 1 cycle from accepted address phase to registered outputs.
// Backpressure: hready low, hsel low or BUSY hold all state; beat_valid drops for that cycle.
// Ports: clk/rstn; AHB address phase hsel, haddr, htrans, hburst, hsize, hready;
//        outputs beat_addr, beat_valid, beat_idx, beat_last, burst_err (one-cycle pulse).
module burst_addr_gen
    import burst_addr_gen_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_SIZE = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hburst,
    input  logic [2:0]        hsize,
    input  logic              hready,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              beat_valid,
    output logic [3:0]        beat_idx,
    output logic              beat_last,
    output logic              burst_err
);

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [ADDR_W-1:0] r_next,  w_next_nxt;
    logic [2:0]        r_hsize, w_hsize_nxt;
    logic [4:0]        r_beats, w_beats_nxt;
    logic              r_wrap,  w_wrap_nxt;
    logic [3:0]        r_idx,   w_idx_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_last,  w_last_nxt;
    logic              r_err,   w_err_nxt;

    burst_info_t       w_info;
    logic              w_xfer;
    logic              w_is_nonseq;
    logic [ADDR_W-1:0] w_step;
    logic              w_size_bad;
    logic              w_misaligned;
    logic [ADDR_W-1:0] w_na_addr;
    logic [2:0]        w_na_hsize;
    logic [4:0]        w_na_beats;
    logic              w_na_wrap;
    logic [ADDR_W-1:0] w_calc_addr;

    assign w_info       = burst_info(hburst);
    assign w_xfer       = hsel & hready;
    assign w_is_nonseq  = (htrans == TRANS_NONSEQ);
    assign w_step       = ADDR_W'(1) << hsize;
    assign w_size_bad   = (hsize > 3'(MAX_SIZE));
    assign w_misaligned = |(haddr & (w_step - ADDR_W'(1)));

    // One adder serves both cases: a NONSEQ computes from the new haddr/shape,
    // a SEQ advances the stored expected address with the latched shape.
    assign w_na_addr  = w_is_nonseq ? haddr        : r_next;
    assign w_na_hsize = w_is_nonseq ? hsize        : r_hsize;
    assign w_na_beats = w_is_nonseq ? w_info.beats : r_beats;
    assign w_na_wrap  = w_is_nonseq ? w_info.wrap  : r_wrap;

    burst_next_addr #(
        .ADDR_W (ADDR_W)
    ) u_next_addr (
        .i_addr      (w_na_addr),
        .i_hsize     (w_na_hsize),
        .i_beats     (w_na_beats),
        .i_wrap      (w_na_wrap),
        .o_next_addr (w_calc_addr)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_next  <= '0;
            r_hsize <= '0;
            r_beats <= '0;
            r_wrap  <= 1'b0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_next  <= w_next_nxt;
            r_hsize <= w_hsize_nxt;
            r_beats <= w_beats_nxt;
            r_wrap  <= w_wrap_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_next_nxt  = r_next;
        w_hsize_nxt = r_hsize;
        w_beats_nxt = r_beats;
        w_wrap_nxt  = r_wrap;
        w_idx_nxt   = r_idx;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_xfer) begin
            case (htrans)
                TRANS_NONSEQ: begin
                    // Also covers early termination: any burst in flight is simply replaced
                    w_addr_nxt  = haddr;
                    w_next_nxt  = w_calc_addr;
                    w_hsize_nxt = hsize;
                    w_beats_nxt = w_info.beats;
                    w_wrap_nxt  = w_info.wrap;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (w_info.beats == 5'd1);
                    w_err_nxt   = w_size_bad | w_misaligned;
                    if (hburst == BURST_INCR) begin
                        w_state_nxt = ST_UNDEF;
                    end else if (w_last_nxt) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FIXED;
                    end
                end
                TRANS_SEQ: begin
                    if (r_state == ST_IDLE) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        // The generated address wins even when the master's haddr disagrees
                        w_addr_nxt  = r_next;
                        w_next_nxt  = w_calc_addr;
                        w_idx_nxt   = r_idx + 4'd1;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (r_state == ST_FIXED) &&
                                      (({1'b0, r_idx} + 5'd1) == (r_beats - 5'd1));
                        w_err_nxt   = (haddr != r_next) |
                                      ((r_state == ST_FIXED) && !r_wrap &&
                                       (r_next[ADDR_W-1:KB_BIT] != r_addr[ADDR_W-1:KB_BIT]));
                        if (w_last_nxt) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                TRANS_IDLE: begin
                    // Abandoning a fixed-length burst is a protocol error; ending INCR is not
                    w_err_nxt   = (r_state == ST_FIXED);
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    // BUSY: hold everything
                end
            endcase
        end
    end

    assign beat_addr  = r_addr;
    assign beat_valid = r_valid;
    assign beat_idx   = r_idx;
    assign beat_last  = r_last;
    assign burst_err  = r_err;

endmodule

// File: tb/tb_burst_addr_gen.sv
module tb_burst_addr_gen;
    import burst_addr_gen_pkg::*;

    logic        clk;
    logic        rstn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] beat_addr;
    logic        beat_valid;
    logic [3:0]  beat_idx;
    logic        beat_last;
    logic        burst_err;

    int n_checks = 0;
    int n_errors = 0;

    burst_addr_gen #(.ADDR_W(32), .MAX_SIZE(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hburst     (hburst),
        .hsize      (hsize),
        .hready     (hready),
        .beat_addr  (beat_addr),
        .beat_valid (beat_valid),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .burst_err  (burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one address phase at a falling edge; on return the registered
    // outputs for that phase are visible (one rising edge has passed).
    task automatic drv(input logic sel, input logic rdy, input logic [1:0] tr,
                       input logic [2:0] bu, input logic [2:0] sz, input logic [31:0] ad);
        hsel = sel; hready = rdy; htrans = tr; hburst = bu; hsize = sz; haddr = ad;
        @(negedge clk);
    endtask

    // Address of beat k computed directly from the start address.
    function automatic logic [31:0] ref_addr(input logic [31:0] start, input int k,
                                             input int n, input bit wrap, input int step);
        longint s, bnd, off;
        s = longint'(start);
        if (wrap) begin
            bnd = longint'(n) * longint'(step);
            off = s % bnd;
            return 32'(s - off + (off + longint'(k) * longint'(step)) % bnd);
        end
        return 32'(s + longint'(k) * longint'(step));
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        hsel = 1'b0; hready = 1'b1; htrans = TRANS_IDLE; hburst = '0; hsize = '0; haddr = '0;
        @(negedge clk);
        n_checks++;
        if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !== 39'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%0b a=%h i=%0d l=%0b e=%0b, exp all zero",
                     beat_valid, beat_addr, beat_idx, beat_last, burst_err);
        end
        rstn = 1'b1;
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
        n_checks++;
        if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !== 39'd0) begin
            n_errors++;
            $display("FAIL reset_release_idle: got v=%0b a=%h i=%0d l=%0b e=%0b, exp all zero",
                     beat_valid, beat_addr, beat_idx, beat_last, burst_err);
        end
    endtask

    task automatic test_wrap4();
        logic [31:0] ea [4];
        ea = '{32'h38, 32'h3C, 32'h30, 32'h34};
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 1'b1, (k == 0) ? TRANS_NONSEQ : TRANS_SEQ, BURST_WRAP4, 3'd2, ea[k]);
            n_checks++;
            if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !==
                {1'b1, ea[k], 4'(k), (k == 3), 1'b0}) begin
                n_errors++;
                $display("FAIL wrap4 beat %0d: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=1 a=%h i=%0d l=%0b e=0",
                         k, beat_valid, beat_addr, beat_idx, beat_last, burst_err, ea[k], k, (k == 3));
            end
        end
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
    endtask

    task automatic test_incr8();
        logic [31:0] ea;
        for (int k = 0; k < 8; k++) begin
            ea = 32'h100 + 32'(2 * k);
            drv(1'b1, 1'b1, (k == 0) ? TRANS_NONSEQ : TRANS_SEQ, BURST_INCR8, 3'd1, ea);
            n_checks++;
            if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !==
                {1'b1, ea, 4'(k), (k == 7), 1'b0}) begin
                n_errors++;
                $display("FAIL incr8 beat %0d: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=1 a=%h i=%0d l=%0b e=0",
                         k, beat_valid, beat_addr, beat_idx, beat_last, burst_err, ea, k, (k == 7));
            end
        end
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
    endtask

    task automatic test_wrap8_busy();
        logic [31:0] ea [8];
        ea = '{32'h14, 32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                drv(1'b1, 1'b1, TRANS_BUSY, BURST_WRAP8, 3'd2, 32'h00);
                n_checks++;
                if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !==
                    {1'b0, 32'h1C, 4'd2, 1'b0, 1'b0}) begin
                    n_errors++;
                    $display("FAIL wrap8_busy_hold: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=0 a=1c i=2 l=0 e=0",
                             beat_valid, beat_addr, beat_idx, beat_last, burst_err);
                end
            end
            drv(1'b1, 1'b1, (k == 0) ? TRANS_NONSEQ : TRANS_SEQ, BURST_WRAP8, 3'd2, ea[k]);
            n_checks++;
            if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !==
                {1'b1, ea[k], 4'(k), (k == 7), 1'b0}) begin
                n_errors++;
                $display("FAIL wrap8 beat %0d: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=1 a=%h i=%0d l=%0b e=0",
                         k, beat_valid, beat_addr, beat_idx, beat_last, burst_err, ea[k], k, (k == 7));
            end
        end
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
    endtask

    task automatic test_early_term();
        logic [31:0] ea;
        drv(1'b1, 1'b1, TRANS_NONSEQ, BURST_INCR4, 3'd2, 32'h200);
        drv(1'b1, 1'b1, TRANS_SEQ,    BURST_INCR4, 3'd2, 32'h204);
        for (int k = 0; k < 4; k++) begin
            ea = 32'h400 + 32'(4 * k);
            drv(1'b1, 1'b1, (k == 0) ? TRANS_NONSEQ : TRANS_SEQ, BURST_INCR4, 3'd2, ea);
            n_checks++;
            if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !==
                {1'b1, ea, 4'(k), (k == 3), 1'b0}) begin
                n_errors++;
                $display("FAIL early_term beat %0d: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=1 a=%h i=%0d l=%0b e=0",
                         k, beat_valid, beat_addr, beat_idx, beat_last, burst_err, ea, k, (k == 3));
            end
        end
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
    endtask

    task automatic test_wrap16_err();
        logic [31:0] ea;
        logic [31:0] ad;
        for (int k = 0; k < 16; k++) begin
            ea = 32'h40 + 32'((8 + 4 * k) % 64);
            ad = (k == 5) ? (ea ^ 32'h100) : ea;
            drv(1'b1, 1'b1, (k == 0) ? TRANS_NONSEQ : TRANS_SEQ, BURST_WRAP16, 3'd2, ad);
            n_checks++;
            if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !==
                {1'b1, ea, 4'(k), (k == 15), (k == 5)}) begin
                n_errors++;
                $display("FAIL wrap16_err beat %0d: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=1 a=%h i=%0d l=%0b e=%0b",
                         k, beat_valid, beat_addr, beat_idx, beat_last, burst_err, ea, k, (k == 15), (k == 5));
            end
        end
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
    endtask

    task automatic test_reset_mid();
        drv(1'b1, 1'b1, TRANS_NONSEQ, BURST_INCR16, 3'd2, 32'h1000);
        for (int k = 1; k < 4; k++) begin
            drv(1'b1, 1'b1, TRANS_SEQ, BURST_INCR16, 3'd2, 32'h1000 + 32'(4 * k));
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !== 39'd0) begin
            n_errors++;
            $display("FAIL reset_async: got v=%0b a=%h i=%0d l=%0b e=%0b, exp all zero",
                     beat_valid, beat_addr, beat_idx, beat_last, burst_err);
        end
        @(negedge clk);
        rstn = 1'b1;
        drv(1'b1, 1'b1, TRANS_SEQ, BURST_INCR16, 3'd2, 32'h1010);
        n_checks++;
        if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !==
            {1'b0, 32'h0, 4'd0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL seq_after_reset: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=0 a=0 i=0 l=0 e=1",
                     beat_valid, beat_addr, beat_idx, beat_last, burst_err);
        end
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
    endtask

    task automatic test_boundary();
        logic [41:0] st [13];   // {sel, rdy, trans, burst, size, addr}
        logic [38:0] ex [13];   // {valid, addr, idx, last, err}
        st[0]  = {2'b11, TRANS_NONSEQ, BURST_INCR4,  3'd2, 32'h3F8}; ex[0]  = {1'b1, 32'h3F8, 4'd0, 1'b0, 1'b0};
        st[1]  = {2'b11, TRANS_SEQ,    BURST_INCR4,  3'd2, 32'h3FC}; ex[1]  = {1'b1, 32'h3FC, 4'd1, 1'b0, 1'b0};
        st[2]  = {2'b11, TRANS_SEQ,    BURST_INCR4,  3'd2, 32'h400}; ex[2]  = {1'b1, 32'h400, 4'd2, 1'b0, 1'b1};
        st[3]  = {2'b11, TRANS_SEQ,    BURST_INCR4,  3'd2, 32'h404}; ex[3]  = {1'b1, 32'h404, 4'd3, 1'b1, 1'b0};
        st[4]  = {2'b11, TRANS_NONSEQ, BURST_INCR,   3'd2, 32'h502}; ex[4]  = {1'b1, 32'h502, 4'd0, 1'b0, 1'b1};
        st[5]  = {2'b11, TRANS_IDLE,   BURST_INCR,   3'd2, 32'h0};   ex[5]  = {1'b0, 32'h502, 4'd0, 1'b0, 1'b0};
        st[6]  = {2'b11, TRANS_NONSEQ, BURST_SINGLE, 3'd3, 32'h600}; ex[6]  = {1'b1, 32'h600, 4'd0, 1'b1, 1'b1};
        st[7]  = {2'b11, TRANS_NONSEQ, BURST_INCR8,  3'd0, 32'h10};  ex[7]  = {1'b1, 32'h10,  4'd0, 1'b0, 1'b0};
        st[8]  = {2'b11, TRANS_IDLE,   BURST_INCR8,  3'd0, 32'h0};   ex[8]  = {1'b0, 32'h10,  4'd0, 1'b0, 1'b1};
        st[9]  = {2'b11, TRANS_SEQ,    BURST_INCR8,  3'd0, 32'h11};  ex[9]  = {1'b0, 32'h10,  4'd0, 1'b0, 1'b1};
        st[10] = {2'b01, TRANS_NONSEQ, BURST_INCR4,  3'd2, 32'h700}; ex[10] = {1'b0, 32'h10,  4'd0, 1'b0, 1'b0};
        st[11] = {2'b10, TRANS_NONSEQ, BURST_INCR4,  3'd2, 32'h700}; ex[11] = {1'b0, 32'h10,  4'd0, 1'b0, 1'b0};
        st[12] = {2'b11, TRANS_SEQ,    BURST_INCR4,  3'd2, 32'h704}; ex[12] = {1'b0, 32'h10,  4'd0, 1'b0, 1'b1};
        for (int k = 0; k < 13; k++) begin
            drv(st[k][41], st[k][40], st[k][39:38], st[k][37:35], st[k][34:32], st[k][31:0]);
            n_checks++;
            if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !== ex[k]) begin
                n_errors++;
                $display("FAIL boundary row %0d: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=%0b a=%h i=%0d l=%0b e=%0b",
                         k, beat_valid, beat_addr, beat_idx, beat_last, burst_err,
                         ex[k][38], ex[k][37:6], ex[k][5:2], ex[k][1], ex[k][0]);
            end
        end
        drv(1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 3'd2, 32'h0);
    endtask

    task automatic test_random();
        bit          m_active = 1'b0;
        bit          m_fixed  = 1'b0;
        bit          m_wrap   = 1'b0;
        int          m_n = 0, m_step = 1, m_k = 0;
        logic [31:0] m_start = '0;
        logic        e_v, e_l, e_e;
        logic [31:0] e_a, cur;
        logic [3:0]  e_i;
        logic        sel, rdy;
        logic [1:0]  tr;
        logic [2:0]  bu, sz;
        logic [31:0] ad;
        int          r;
        // Outputs after the previous test end: last beat of row 7 held, then idle
        e_a = beat_addr; e_i = beat_idx;
        for (int c = 0; c < 1500; c++) begin
            r   = int'($urandom_range(0, 99));
            sel = 1'b1; rdy = 1'b1;
            bu  = 3'($urandom_range(0, 7));
            sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            ad  = $urandom;
            tr  = TRANS_NONSEQ;
            if (m_active) begin
                if (r < 60) begin
                    tr = TRANS_SEQ;
                    if (r < 55) ad = ref_addr(m_start, m_k + 1, m_n, m_wrap, m_step);
                end else if (r < 68) tr = TRANS_BUSY;
                else if (r < 74) begin rdy = 1'b0; tr = TRANS_SEQ; end
                else if (r < 78) begin sel = 1'b0; tr = TRANS_SEQ; end
                else if (r < 85) tr = TRANS_IDLE;
            end else begin
                if (r >= 75) tr = TRANS_IDLE;
                else if (r >= 65) tr = TRANS_SEQ;
            end
            if (tr == TRANS_NONSEQ) begin
                // Bias starts near a 1 KB edge, usually aligned to the transfer size
                if ($urandom_range(0, 2) == 0) ad = {ad[31:10], 10'h3C0} | {26'd0, ad[5:0]};
                if ($urandom_range(0, 9) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            end

            // Reference behaviour
            e_v = 1'b0; e_l = 1'b0; e_e = 1'b0;
            if (sel && rdy) begin
                if (tr == TRANS_NONSEQ) begin
                    case (bu)
                        3'd0:       m_n = 1;
                        3'd1:       m_n = 0;
                        3'd2, 3'd3: m_n = 4;
                        3'd4, 3'd5: m_n = 8;
                        default:    m_n = 16;
                    endcase
                    m_wrap   = (bu == 3'd2) || (bu == 3'd4) || (bu == 3'd6);
                    m_fixed  = (bu != 3'd1);
                    m_step   = 1 << sz;
                    m_start  = ad;
                    m_k      = 0;
                    m_active = 1'b1;
                    e_v = 1'b1; e_a = ad; e_i = 4'd0;
                    e_l = (m_n == 1);
                    e_e = (sz > 3'd2) || ((ad % 32'(m_step)) != 0);
                    if (e_l) m_active = 1'b0;
                end else if (tr == TRANS_SEQ) begin
                    if (!m_active) e_e = 1'b1;
                    else begin
                        m_k++;
                        cur = ref_addr(m_start, m_k, m_n, m_wrap, m_step);
                        e_v = 1'b1; e_a = cur; e_i = 4'(m_k);
                        e_l = m_fixed && (m_k == m_n - 1);
                        e_e = (ad != cur) || (m_fixed && !m_wrap &&
                              ((cur >> 10) != (ref_addr(m_start, m_k - 1, m_n, m_wrap, m_step) >> 10)));
                        if (e_l) m_active = 1'b0;
                    end
                end else if (tr == TRANS_IDLE) begin
                    e_e = m_active && m_fixed;
                    m_active = 1'b0;
                end
            end

            drv(sel, rdy, tr, bu, sz, ad);
            n_checks++;
            if ({beat_valid, beat_addr, beat_idx, beat_last, burst_err} !== {e_v, e_a, e_i, e_l, e_e}) begin
                n_errors++;
                $display("FAIL random cyc %0d tr=%0d bu=%0d sz=%0d ad=%h: got v=%0b a=%h i=%0d l=%0b e=%0b, exp v=%0b a=%h i=%0d l=%0b e=%0b",
                         c, tr, bu, sz, ad, beat_valid, beat_addr, beat_idx, beat_last, burst_err,
                         e_v, e_a, e_i, e_l, e_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap4();
        test_incr8();
        test_wrap8_busy();
        test_early_term();
        test_wrap16_err();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
